// File: rtl/nios_cpu_pio_pkg.sv
// -----------------------------------------------------------------------------
// nios_cpu_pio_pkg
// Shared constants for the bidirectional PIO slave:
//   - word addresses of the Avalon-MM register map
//   - edge-capture mode selectors for the EDGE_TYPE parameter
// -----------------------------------------------------------------------------
package nios_cpu_pio_pkg;

    // Register map (word addresses). 6 and 7 are unmapped.
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    // Edge-capture modes.
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_cpu_pio_sync.sv
// -----------------------------------------------------------------------------
// nios_cpu_pio_sync
// WIDTH-wide, STAGES-deep flop chain bringing asynchronous pins into the clk
// domain. All stages clear asynchronously on reset_n.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   i_d      asynchronous pin inputs
//   o_q      synchronised inputs (last stage)
// -----------------------------------------------------------------------------
module nios_cpu_pio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/nios_cpu_pio_ext.sv
// -----------------------------------------------------------------------------
// nios_cpu_pio_ext
// Bidirectional, parametrised PIO Avalon-MM slave for the Nios CPU subsystem.
// Per-bit direction, atomic set/clear of the output latch, synchronised input
// sampling, sticky edge capture and a maskable level interrupt.
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address (see nios_cpu_pio_pkg)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   read_n      active-low read strobe, qualified by chipselect
//   writedata   write data, [WIDTH-1:0] used
//   readdata    registered read data, loaded one cycle after the read strobe
//   in_port     asynchronous pin inputs
//   out_port    output latch
//   out_oe      output enables (direction register, 1 = output)
//   irq         level interrupt, |(edge & mask)
// -----------------------------------------------------------------------------
module nios_cpu_pio_ext
    import nios_cpu_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_oe,
    output logic             irq
);

    // Capture stays disabled until the synchroniser and prev flop hold real
    // pin values, so a pin high through reset does not look like a rise.
    localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_latch;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_prev_in;
    logic [31:0]      r_rdata;
    logic [2:0]       r_warm;

    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_det;
    logic             w_cap_en;
    logic [WIDTH-1:0] w_latch_d;
    logic [WIDTH-1:0] w_dir_d;
    logic [WIDTH-1:0] w_mask_d;
    logic [WIDTH-1:0] w_edge_clr;
    logic [WIDTH-1:0] w_edge_d;
    logic [WIDTH-1:0] w_rd_val;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_rd        = chipselect & ~read_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    // ---------------------------------------------------------------- inputs
    nios_cpu_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (in_port),
        .o_q     (w_sync_in)
    );

    // ----------------------------------------------------------- edge detect
    assign w_rise   = w_sync_in & ~r_prev_in;
    assign w_fall   = ~w_sync_in & r_prev_in;
    assign w_cap_en = (r_warm == WARM_DONE);

    always_comb begin
        w_det = w_rise;
        case (EDGE_TYPE)
            EDGE_FALL: w_det = w_fall;
            EDGE_ANY:  w_det = w_rise | w_fall;
            default:   w_det = w_rise;
        endcase
    end

    // ---------------------------------------------------------- write decode
    always_comb begin
        w_latch_d  = r_latch;
        w_dir_d    = r_dir;
        w_mask_d   = r_mask;
        w_edge_clr = '0;
        if (w_wr) begin
            case (address)
                ADDR_DATA:    w_latch_d  = w_wd;
                ADDR_DIR:     w_dir_d    = w_wd;
                ADDR_IRQMASK: w_mask_d   = w_wd;
                ADDR_EDGE:    w_edge_clr = w_wd;
                ADDR_OUTSET:  w_latch_d  = r_latch | w_wd;
                ADDR_OUTCLR:  w_latch_d  = r_latch & ~w_wd;
                default:      ;
            endcase
        end
    end

    // A new edge is OR-ed in after the clear, so it wins a same-cycle clear.
    assign w_edge_d = (r_edge & ~w_edge_clr) | (w_cap_en ? w_det : '0);

    // -------------------------------------------------------------- read mux
    // Uses current register values, so a same-cycle write is not visible.
    always_comb begin
        w_rd_val = '0;
        case (address)
            ADDR_DATA:    w_rd_val = (w_sync_in & ~r_dir) | (r_latch & r_dir);
            ADDR_DIR:     w_rd_val = r_dir;
            ADDR_IRQMASK: w_rd_val = r_mask;
            ADDR_EDGE:    w_rd_val = r_edge;
            default:      w_rd_val = '0;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_latch   <= RESET_VALUE;
            r_dir     <= DIR_RESET;
            r_mask    <= '0;
            r_edge    <= '0;
            r_prev_in <= '0;
            r_rdata   <= '0;
            r_warm    <= '0;
        end else begin
            r_latch   <= w_latch_d;
            r_dir     <= w_dir_d;
            r_mask    <= w_mask_d;
            r_edge    <= w_edge_d;
            r_prev_in <= w_sync_in;
            if (w_rd) begin
                r_rdata <= 32'(w_rd_val);
            end
            if (!w_cap_en) begin
                r_warm <= r_warm + 3'd1;
            end
        end
    end

    // --------------------------------------------------------------- outputs
    assign out_port = r_latch;
    assign out_oe   = r_dir;
    assign readdata = r_rdata;
    assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_nios_cpu_pio_ext.sv
// -----------------------------------------------------------------------------
// tb_nios_cpu_pio_ext
// Self-checking bench for nios_cpu_pio_ext (WIDTH=8, RESET_VALUE=A5,
// DIR_RESET=FF, SYNC_STAGES=2, rising-edge capture).
// -----------------------------------------------------------------------------
module tb_nios_cpu_pio_ext;

    localparam int         S  = 2;
    localparam int         ET = 0;
    localparam logic [7:0] RV = 8'hA5;
    localparam logic [7:0] DR = 8'hFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_port = '0;
    logic [7:0]  out_port;
    logic [7:0]  out_oe;
    logic        irq;

    always #5 clk = ~clk;

    nios_cpu_pio_ext #(
        .WIDTH       (8),
        .RESET_VALUE (RV),
        .DIR_RESET   (DR),
        .SYNC_STAGES (S),
        .EDGE_TYPE   (ET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_oe     (out_oe),
        .irq        (irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Reference model: register contents plus the pin value seen at every
    // clock edge since reset. The synchronised view of the pins is simply
    // that history delayed by S edges.
    logic [7:0]  m_latch, m_dir, m_mask, m_edge;
    logic [31:0] m_rdata;
    int          k;
    logic [7:0]  hist [0:4095];

    function automatic logic [7:0] pin_at(input int idx);
        if (idx < 1) return 8'h00;
        return hist[idx];
    endfunction

    task automatic model_reset();
        m_latch = RV;
        m_dir   = DR;
        m_mask  = '0;
        m_edge  = '0;
        m_rdata = '0;
        k       = 0;
    endtask

    task automatic model_edge(input logic cs, input logic wr, input logic rd,
                              input logic [2:0] a, input logic [31:0] wd,
                              input logic [7:0] pin);
        logic [7:0] s_now, p_now, det, clr, rv, d8;
        d8 = wd[7:0];
        k++;
        if (k > 4095) begin
            $display("FAIL hist_overflow: got %0d, expected <= 4095", k);
            $fatal(1);
        end
        hist[k] = pin;
        s_now = pin_at(k - S);
        p_now = pin_at(k - S - 1);
        case (ET)
            1:       det = ~s_now & p_now;
            2:       det = s_now ^ p_now;
            default: det = s_now & ~p_now;
        endcase
        if (k <= S + 1) det = '0;
        if (cs && rd) begin
            case (a)
                3'd0:    rv = (s_now & ~m_dir) | (m_latch & m_dir);
                3'd1:    rv = m_dir;
                3'd2:    rv = m_mask;
                3'd3:    rv = m_edge;
                default: rv = '0;
            endcase
            m_rdata = {24'h0, rv};
        end
        clr = (cs && wr && a == 3'd3) ? d8 : 8'h00;
        if (cs && wr) begin
            case (a)
                3'd0:    m_latch = d8;
                3'd1:    m_dir   = d8;
                3'd2:    m_mask  = d8;
                3'd4:    m_latch = m_latch | d8;
                3'd5:    m_latch = m_latch & ~d8;
                default: ;
            endcase
        end
        m_edge = (m_edge & ~clr) | det;
    endtask

    task automatic check_model(input string tag);
        check_val($sformatf("%s out_port", tag), 32'(out_port), 32'(m_latch));
        check_val($sformatf("%s out_oe", tag), 32'(out_oe), 32'(m_dir));
        check_val($sformatf("%s irq", tag), 32'(irq), 32'(|(m_edge & m_mask)));
        check_val($sformatf("%s readdata", tag), readdata, m_rdata);
    endtask

    // One bus cycle: drive, clock, update model, sample 1 time unit later.
    task automatic cycle(input logic cs, input logic wr, input logic rd, input logic [2:0] a,
                         input logic [31:0] wd, input logic [7:0] pin);
        chipselect = cs;
        write_n    = ~wr;
        read_n     = ~rd;
        address    = a;
        writedata  = wd;
        in_port    = pin;
        @(posedge clk);
        model_edge(cs, wr, rd, a, wd, pin);
        #1;
        check_model("cyc");
    endtask

    task automatic idle(input logic [7:0] pin);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, pin);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] pin);
        cycle(1'b1, 1'b1, 1'b0, a, wd, pin);
    endtask

    task automatic rd_reg(input logic [2:0] a, input logic [7:0] pin);
        cycle(1'b1, 1'b0, 1'b1, a, 32'h0, pin);
    endtask

    task automatic do_reset(input logic [7:0] pin);
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
        in_port    = pin;
        reset_n    = 1'b0;
        #1;
        model_reset();
        check_model("rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0]  pin;
        logic        cs, wr, rd;
        logic [2:0]  a;
        logic [31:0] wd;

        #2;
        do_reset(8'h00);
        check_val("reset out_port", 32'(out_port), 32'h0000_00A5);
        check_val("reset out_oe", 32'(out_oe), 32'h0000_00FF);
        check_val("reset irq", 32'(irq), 32'h0);
        check_val("reset readdata", readdata, 32'h0);

        // Latch write, atomic set, atomic clear.
        wr_reg(3'd0, 32'h0000_000F, 8'h00);
        check_val("data_wr", 32'(out_port), 32'h0F);
        wr_reg(3'd4, 32'hFFFF_FFF0, 8'h00);
        check_val("outset", 32'(out_port), 32'hFF);
        wr_reg(3'd5, 32'h0000_0003, 8'h00);
        check_val("outclr", 32'(out_port), 32'hFC);

        // Mixed-direction DATA read.
        wr_reg(3'd1, 32'h0000_000F, 8'hA0);
        check_val("dir_wr", 32'(out_oe), 32'h0F);
        wr_reg(3'd0, 32'h0000_0005, 8'hA0);
        repeat (S + 1) idle(8'hA0);
        rd_reg(3'd0, 8'hA0);
        check_val("data_rd", readdata, 32'h0000_00A5);

        // Rising edge on bit 0 -> irq exactly S+1 edges after the pin change.
        wr_reg(3'd2, 32'h0000_0001, 8'hA0);
        wr_reg(3'd3, 32'h0000_00FF, 8'hA0);
        check_val("irq_cleared", 32'(irq), 32'h0);
        for (int j = 1; j <= S + 1; j++) begin
            idle(8'hA1);
            if (j == S) check_val("irq_before_edge", 32'(irq), 32'h0);
        end
        check_val("irq_on_edge", 32'(irq), 32'h1);
        rd_reg(3'd3, 8'hA1);
        check_val("edge_rd", readdata, 32'h0000_0001);

        // Clear racing a new rising edge: the edge wins.
        repeat (S + 2) idle(8'hA0);
        check_val("edge_sticky", 32'(irq), 32'h1);
        repeat (S) idle(8'hA1);
        wr_reg(3'd3, 32'h0000_0001, 8'hA1);
        check_val("w1c_race_irq", 32'(irq), 32'h1);
        rd_reg(3'd3, 8'hA1);
        check_val("w1c_race_edge", readdata, 32'h0000_0001);
        wr_reg(3'd3, 32'h0000_0001, 8'hA1);
        check_val("w1c_irq", 32'(irq), 32'h0);
        rd_reg(3'd3, 8'hA1);
        check_val("w1c_edge", readdata, 32'h0);

        // Pins high through reset release: no false edges after warm-up.
        do_reset(8'hFF);
        wr_reg(3'd2, 32'h0000_00FF, 8'hFF);
        repeat (S + 3) idle(8'hFF);
        check_val("warm_irq", 32'(irq), 32'h0);
        rd_reg(3'd3, 8'hFF);
        check_val("warm_edge", readdata, 32'h0);
        check_val("warm_out_port", 32'(out_port), 32'hA5);

        // Randomised traffic, with one reset landing on an in-flight read.
        pin = 8'hFF;
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                wr_reg(3'd1, 32'h0000_003C, pin);
                rd_reg(3'd1, pin);
                check_val("pre_rst_rd", readdata, 32'h0000_003C);
                chipselect = 1'b1;
                read_n     = 1'b0;
                address    = 3'd1;
                #2;
                do_reset(pin);
                check_val("mid_rst_readdata", readdata, 32'h0);
                check_val("mid_rst_out_oe", 32'(out_oe), 32'hFF);
            end
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            cs = ($urandom_range(0, 3) != 0);
            wr = 1'($urandom);
            rd = 1'($urandom);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            cycle(cs, wr, rd, a, wd, pin);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
